// File: rtl/dac_fmt_pkg.sv
// Shared format encodings and saturation/format helpers for the DAC code formatter.
package dac_fmt_pkg;

  localparam logic FMT_OFFSET_BIN = 1'b0;
  localparam logic FMT_TWOS_COMP  = 1'b1;

  function automatic int sat_max(input int unsigned data_w);
    return (1 << (data_w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int unsigned data_w);
    return -(1 << (data_w - 1));
  endfunction

  // Offset binary and two's complement differ only in the MSB, so the flip acts on that bit.
  function automatic logic fmt_flip(input logic value_msb, input logic fmt);
    return (fmt == FMT_OFFSET_BIN) ? ~value_msb : value_msb;
  endfunction

endpackage

// File: rtl/dac_ch_trim_sat.sv
// One channel of stage 2: DC trim add, saturation, mute, output encode and sticky clip flag.
module dac_ch_trim_sat
  import dac_fmt_pkg::*;
#(
  parameter int unsigned DATA_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s1_valid_i,
  input  logic [DATA_W-1:0] dec_i,
  input  logic [DATA_W-1:0] trim_i,
  input  logic              out_fmt_i,
  input  logic              mute_i,
  input  logic              sat_clr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              sat_flag_o
);

  localparam logic [DATA_W-1:0] SatMax = DATA_W'(sat_max(DATA_W));
  localparam logic [DATA_W-1:0] SatMin = DATA_W'(sat_min(DATA_W));

  logic [DATA_W:0]   sum;
  logic              clip;
  logic [DATA_W-1:0] sat_val;
  logic [DATA_W-1:0] pre_enc;
  logic [DATA_W-1:0] data_d, data_q;
  logic              sat_d, sat_q;

  always_comb begin
    sum  = {dec_i[DATA_W-1], dec_i} + {trim_i[DATA_W-1], trim_i};
    // Overflow shows up as disagreement between the guard bit and the result MSB.
    clip = sum[DATA_W] ^ sum[DATA_W-1];
    if (clip) begin
      sat_val = sum[DATA_W] ? SatMin : SatMax;
    end else begin
      sat_val = sum[DATA_W-1:0];
    end
    pre_enc = mute_i ? '0 : sat_val;
    data_d  = data_q;
    if (s1_valid_i) begin
      data_d = {fmt_flip(pre_enc[DATA_W-1], out_fmt_i), pre_enc[DATA_W-2:0]};
    end
    // A new clip outranks a simultaneous clear.
    sat_d = (s1_valid_i & ~mute_i & clip) | (sat_q & ~sat_clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      sat_q  <= sat_d;
    end
  end

  assign data_o     = data_q;
  assign sat_flag_o = sat_q;

endmodule

// File: rtl/dac_code_formatter.sv
// Multi-channel DAC code formatter: input decode (stage 1), then per-channel trim/saturate/encode.
module dac_code_formatter
  import dac_fmt_pkg::*;
#(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned TRIM_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     in_fmt,
  input  logic                     out_fmt,
  input  logic [NUM_CH*TRIM_W-1:0] trim,
  input  logic                     mute,
  input  logic                     sat_clr,
  output logic                     out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        sat_flag
);

  logic [NUM_CH-1:0][DATA_W-1:0] dec_d, dec_q;
  logic [NUM_CH-1:0][DATA_W-1:0] trim_d, trim_q;
  logic [NUM_CH-1:0][DATA_W-1:0] ch_data;
  logic                          out_fmt_d, out_fmt_q;
  logic                          mute_d, mute_q;
  logic                          s1_valid_q;
  logic                          out_valid_q;

  always_comb begin
    dec_d     = dec_q;
    trim_d    = trim_q;
    out_fmt_d = out_fmt_q;
    mute_d    = mute_q;
    if (in_valid) begin
      for (int k = 0; k < NUM_CH; k++) begin
        dec_d[k]  = {fmt_flip(in_data[k*DATA_W + DATA_W - 1], in_fmt),
                     in_data[k*DATA_W +: DATA_W-1]};
        trim_d[k] = {{(DATA_W - TRIM_W){trim[k*TRIM_W + TRIM_W - 1]}},
                     trim[k*TRIM_W +: TRIM_W]};
      end
      out_fmt_d = out_fmt;
      mute_d    = mute;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q       <= '0;
      trim_q      <= '0;
      out_fmt_q   <= FMT_OFFSET_BIN;
      mute_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      dec_q       <= dec_d;
      trim_q      <= trim_d;
      out_fmt_q   <= out_fmt_d;
      mute_q      <= mute_d;
      s1_valid_q  <= in_valid;
      out_valid_q <= s1_valid_q;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    dac_ch_trim_sat #(
      .DATA_W(DATA_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .s1_valid_i(s1_valid_q),
      .dec_i     (dec_q[k]),
      .trim_i    (trim_q[k]),
      .out_fmt_i (out_fmt_q),
      .mute_i    (mute_q),
      .sat_clr_i (sat_clr),
      .data_o    (ch_data[k]),
      .sat_flag_o(sat_flag[k])
    );
    assign out_data[k*DATA_W +: DATA_W] = ch_data[k];
  end

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dac_code_formatter.sv
// Self-checking bench for dac_code_formatter: directed vector table plus multi-cycle sequences.
module tb_dac_code_formatter;

  localparam int unsigned DATA_W = 14;
  localparam int unsigned NUM_CH = 2;
  localparam int unsigned TRIM_W = 8;

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     in_fmt;
  logic                     out_fmt;
  logic [NUM_CH*TRIM_W-1:0] trim;
  logic                     mute;
  logic                     sat_clr;
  logic                     out_valid;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        sat_flag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [13:0] d0;
    logic [13:0] d1;
    logic        in_fmt;
    logic        out_fmt;
    logic [7:0]  t0;
    logic [7:0]  t1;
    logic        mute;
    logic [13:0] e0;
    logic [13:0] e1;
    logic [1:0]  esat;
  } vec_t;

  vec_t vecs[8];

  dac_code_formatter #(
    .DATA_W(DATA_W),
    .NUM_CH(NUM_CH),
    .TRIM_W(TRIM_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_fmt   (in_fmt),
    .out_fmt  (out_fmt),
    .trim     (trim),
    .mute     (mute),
    .sat_clr  (sat_clr),
    .out_valid(out_valid),
    .out_data (out_data),
    .sat_flag (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [13:0] d0, input logic [13:0] d1,
                       input logic inf, input logic outf, input logic [7:0] t0,
                       input logic [7:0] t1, input logic m);
    in_valid = v;
    in_data  = {d1, d0};
    in_fmt   = inf;
    out_fmt  = outf;
    trim     = {t1, t0};
    mute     = m;
  endtask

  logic [27:0] held;

  initial begin
    rst_n   = 1'b0;
    sat_clr = 1'b0;
    drive(1'b0, 14'h0, 14'h0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0);

    vecs[0] = '{14'h03E8, 14'h2010, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 14'h23E8, 14'h0010, 2'b00};
    vecs[1] = '{14'h1FFF, 14'h0ABC, 1'b1, 1'b1, 8'h05, 8'h10, 1'b0, 14'h1FFF, 14'h0ACC, 2'b01};
    vecs[2] = '{14'h0005, 14'h2000, 1'b1, 1'b0, 8'hFD, 8'hFF, 1'b0, 14'h2002, 14'h0000, 2'b10};
    vecs[3] = '{14'h1FFF, 14'h2000, 1'b1, 1'b0, 8'h05, 8'hFF, 1'b1, 14'h2000, 14'h2000, 2'b00};
    vecs[4] = '{14'h1234, 14'h0567, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 14'h0000, 14'h0000, 2'b00};
    vecs[5] = '{14'h3FFF, 14'h0000, 1'b0, 1'b0, 8'h01, 8'h80, 1'b0, 14'h3FFF, 14'h0000, 2'b11};
    vecs[6] = '{14'h0100, 14'h3F00, 1'b1, 1'b1, 8'h7F, 8'h80, 1'b0, 14'h017F, 14'h3E80, 2'b00};
    vecs[7] = '{14'h2000, 14'h1FFF, 1'b0, 1'b1, 8'hFF, 8'h01, 1'b0, 14'h3FFF, 14'h0000, 2'b00};

    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset sat_flag", 32'(sat_flag), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: one isolated sample each, checked after the 2-cycle latency, then a bubble.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].d0, vecs[i].d1, vecs[i].in_fmt, vecs[i].out_fmt,
            vecs[i].t0, vecs[i].t1, vecs[i].mute);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d out_data", i), 32'(out_data), 32'({vecs[i].e1, vecs[i].e0}));
      check($sformatf("vec%0d sat_flag", i), 32'(sat_flag), 32'(vecs[i].esat));
      held    = out_data;
      sat_clr = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d bubble valid", i), 32'(out_valid), 32'd0);
      check($sformatf("vec%0d bubble hold", i), 32'(out_data), 32'(held));
      sat_clr = 1'b0;
    end
    check("flags cleared", 32'(sat_flag), 32'd0);

    // Back-to-back ramp.
    for (int c = 0; c < 8; c++) begin
      if (c >= 2) begin
        check($sformatf("ramp%0d valid", c - 2), 32'(out_valid), 32'd1);
        check($sformatf("ramp%0d ch0", c - 2), 32'(out_data[13:0]), 32'(14'h23E8 + 14'(c - 2)));
      end
      if (c < 6) drive(1'b1, 14'(1000 + c), 14'h0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
      else in_valid = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);

    // out_fmt toggles each cycle; each sample must keep its own setting.
    for (int c = 0; c < 8; c++) begin
      if (c >= 2) begin
        check($sformatf("toggle%0d ch0", c - 2), 32'(out_data[13:0]),
              ((c - 2) % 2 == 1) ? 32'h0100 : 32'h2100);
      end
      if (c < 6) drive(1'b1, 14'h0100, 14'h0100, 1'b1, 1'(c % 2), 8'h00, 8'h00, 1'b0);
      else in_valid = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);

    // Clip and sat_clr land on the same edge: set must win.
    drive(1'b1, 14'h1FFF, 14'h0000, 1'b1, 1'b1, 8'h05, 8'h00, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    sat_clr  = 1'b1;
    @(negedge clk);
    check("sticky set wins", 32'(sat_flag[0]), 32'd1);
    sat_clr = 1'b0;
    @(negedge clk);
    check("sticky holds", 32'(sat_flag[0]), 32'd1);
    sat_clr = 1'b1;
    @(negedge clk);
    check("sticky cleared", 32'(sat_flag[0]), 32'd0);
    sat_clr = 1'b0;
    @(negedge clk);

    // Asynchronous reset with samples in flight.
    drive(1'b1, 14'h1FFF, 14'h0000, 1'b1, 1'b1, 8'h05, 8'h00, 1'b0);
    @(negedge clk);
    drive(1'b1, 14'h0123, 14'h0456, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    drive(1'b1, 14'h0321, 14'h0654, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    check("pre-reset sat_flag", 32'(sat_flag[0]), 32'd1);
    check("pre-reset out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst out_data", 32'(out_data), 32'd0);
    check("async rst sat_flag", 32'(sat_flag), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("post-reset valid%0d", c), 32'(out_valid), 32'd0);
      check($sformatf("post-reset data%0d", c), 32'(out_data), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
